// File: rtl/refill_arb_pkg.sv
// rtl/refill_arb_pkg.sv - shared state encoding, default widths and round-robin pick for refill_arbiter
package refill_arb_pkg;

  localparam int DEF_ADDR_W = 21;
  localparam int DEF_LINE_W = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_e;

  // First set bit of req at or after ptr, wrapping at n (n need not be a power of two).
  function automatic int rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [3:0] idx;
    logic       found;
    int         pick;
    found = 1'b0;
    pick  = int'(ptr);
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (k < n && !found && req[idx[2:0]]) begin
        found = 1'b1;
        pick  = int'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/refill_arbiter_rr_arbiter.sv
// rtl/refill_arbiter_rr_arbiter.sv - round-robin pick with registered pointer, advanced on each grant
module rr_arbiter
  import refill_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [ID_W-1:0]   grant
);

  logic [ID_W-1:0] ptr;

  always_comb grant = ID_W'(rr_pick(8'(req), 3'(ptr), NUM_CH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// rtl/refill_arbiter.sv - NUM_CH-channel line-refill arbiter with ID'd memory handshake and timeout re-issue
// Optional multicast of a delivered line to same-address requesters: REFILL_ARB_MULTICAST_EN
module refill_arbiter
  import refill_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = 1024,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  output logic [NUM_CH-1:0]        ch_line_valid,
  output logic [ADDR_W-1:0]        ch_line_addr,
  output logic [LINE_W-1:0]        ch_line_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [ID_W-1:0]          mem_req_id,
  input  logic                     mem_rsp_valid,
  input  logic [ID_W-1:0]          mem_rsp_id,
  input  logic [LINE_W-1:0]        mem_rsp_data,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   pick, grant_q;
  logic [ADDR_W-1:0] addr_q, line_addr_q;
  logic [LINE_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q, do_grant, rsp_hit, tmo;

  rr_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (ch_req),
    .advance (do_grant),
    .grant   (pick)
  );

  assign rsp_hit = mem_rsp_valid && (mem_rsp_id == grant_q);
  assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (|ch_req) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (mem_req_ready) state_nxt = WAIT;
      WAIT: begin
        // A matching response in the timeout cycle still wins.
        if (rsp_hit)  state_nxt = DELIVER;
        else if (tmo) state_nxt = ISSUE;
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q     <= '0;
      addr_q      <= '0;
      line_addr_q <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (do_grant) begin
        grant_q <= pick;
        addr_q  <= ch_req_addr[int'(pick)*ADDR_W +: ADDR_W];
      end
      if (state == ISSUE && mem_req_ready) cnt_q <= '0;
      else if (state == WAIT)              cnt_q <= cnt_q + 1'b1;
      if (state == WAIT && rsp_hit) begin
        data_q      <= mem_rsp_data;
        line_addr_q <= addr_q;
      end
      if (state == WAIT && !rsp_hit && tmo) err_q <= 1'b1;
    end
  end

  always_comb begin
    ch_line_valid = '0;
    if (state == DELIVER) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (ID_W'(j) == grant_q) ch_line_valid[j] = 1'b1;
`ifdef REFILL_ARB_MULTICAST_EN
        if (ch_req[j] && ch_req_addr[j*ADDR_W +: ADDR_W] == addr_q) ch_line_valid[j] = 1'b1;
`endif
      end
    end
  end

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_id    = grant_q;
  assign ch_line_addr  = line_addr_q;
  assign ch_line_data  = data_q;
  assign busy          = (state != IDLE);
  assign timeout_err   = err_q;

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Parametrised line-refill arbiter between NUM_CH cache miss channels (prog, data, future L1 ports) and a single main-memory line-read port.
- Successor to the fixed two-channel refill path.
- Adds round-robin arbitration, a request/response handshake with ID, a response timeout with re-issue, and optional multicast of a returned line to duplicate requesters.
- Single clock domain; sits between the cache array modules and the memory-side FIFO/controller.

Parameters:
- NUM_CH, 2, number of requesting cache channels (2..8).
- ADDR_W, 21, line address width.
- LINE_W, 512, line width in bits.
- TIMEOUT, 1024, cycles in WAIT before re-issue (≥4).
- ID_W, $clog2(NUM_CH) (min 1), request ID width (derived).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ch_req  in  NUM_CH  per-channel miss request, level, held until ch_line_valid.
- ch_req_addr  in  NUM_CH*ADDR_W  per-channel line address; channel i at bits [i*ADDR_W +: ADDR_W].
- ch_line_valid  out  NUM_CH  one-cycle pulse per delivered channel.
- ch_line_addr  out  ADDR_W  address of delivered line.
- ch_line_data  out  LINE_W  delivered line, shared bus.
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  requested line address.
- mem_req_id  out  ID_W  granted channel index.
- mem_rsp_valid  in  1  response valid, one cycle.
- mem_rsp_id  in  ID_W  response ID.
- mem_rsp_data  in  LINE_W  response line.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky, set on any timeout.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, rr_ptr=0, timeout counter 0, latched grant/addr 0.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE → ISSUE:
  - If any ch_req is set, grant the first requester at or after rr_ptr (wrap at NUM_CH).
  - Latch grant index and address; rr_ptr ← grant+1 mod NUM_CH.
  - Arbitration happens only in IDLE.
- ISSUE:
  - mem_req_valid=1; addr and id held stable.
  - On mem_req_ready=1 → WAIT; clear counter.
  - valid must not drop before ready.
- WAIT:
  - Counter increments each cycle.
  - mem_rsp_valid with mem_rsp_id == latched grant → capture data, go to DELIVER.
  - Response with mismatched ID: ignored.
  - Counter reaching TIMEOUT-1 without match: set timeout_err, return to ISSUE with same addr/id (re-issue).
  - Response and timeout in the same cycle: response wins.
- DELIVER:
  - One cycle. ch_line_valid[grant]=1, ch_line_addr=latched addr, ch_line_data=captured line.
  - Then → IDLE.
  - ch_line_data/addr hold last value outside DELIVER.
- Requester contract: deassert ch_req by the edge ending the DELIVER cycle. Arbiter therefore never re-grants a serviced request.
- Latency: request sampled in IDLE → mem_req_valid next cycle. Minimum miss-to-line latency = 1 (IDLE) + 1 (ISSUE, ready=1) + response wait + 1 (DELIVER).
- ch_req dropping after grant: request still completes. Delivery pulse is produced and the channel may ignore it.
- Latched addr is immune to ch_req_addr changes after grant.
- busy = (state != IDLE).
- timeout_err clears only on reset.
- NUM_CH not a power of two: rr wrap uses explicit compare, not truncation.

Optional Feature:
- Macro REFILL_ARB_MULTICAST_EN.
- Defined: in DELIVER, every channel j with ch_req[j]=1 and ch_req_addr[j] == latched addr also gets ch_line_valid[j]=1 in the same cycle. Those channels must drop ch_req per the same contract; rr_ptr is unaffected.
- Undefined: only the granted channel is pulsed. Duplicates are serviced by separate memory requests.

Decomposition:
- Package refill_arb_pkg holds:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DELIVER=2'd3).
  - default widths (ADDR_W=21, LINE_W=512).
  - function rr_pick(req, ptr) returning the grant index.
- One natural sub-module: rr_arbiter (combinational pick plus registered pointer, parameterised by NUM_CH).

Test Plan:
- Single request: ch_req=01, addr 0x00100, ready=1, rsp id 0 after 5 cycles → mem_req_addr=0x00100, id=0; ch_line_valid=01 for exactly 1 cycle with matching data; busy back to 0.
- Round-robin: both channels held requesting continuously (re-raised after each delivery) → grant order 0,1,0,1 over 4 refills.
- Backpressure: ready low for 7 cycles → mem_req_valid, addr and id constant for all 7 cycles, and WAIT is entered only after ready.
- Wrong ID: rsp id 1 while grant is 0 → no delivery. Correct id 0 later → delivered once.
- Timeout: TIMEOUT=16, no response → timeout_err=1 at cycle 16 of WAIT, mem_req_valid reasserted with same addr; a later response is delivered normally.
- Multicast (REFILL_ARB_MULTICAST_EN): both channels request 0x0ABCD → a single memory request, ch_line_valid=11 in one cycle. Without the macro: two memory requests.
- Reset mid-WAIT: assert reset → all outputs 0 immediately; after release, the held ch_req is re-arbitrated from rr_ptr=0.
